// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8 -- 8-way round-robin arbiter with hold-until-release grants.
//
// A pointer names the requester with the highest priority.  In IDLE the first
// set request bit is chosen, starting at the pointer and wrapping 7->0.  That
// requester gets a registered grant, and the pointer then moves to the slot
// just past it.  The grant is held until the owner raises done or drops its
// request.  There is always at least one idle cycle between two grants.
//
// Optional feature (macro ARB_TIMEOUT_EN): if the owner has not released by
// the MAX_HOLD-th cycle of its grant, the grant is forced off and timeout
// pulses for one cycle.  Without the macro, grants are unbounded and timeout
// is tied to 0.
//
// Parameters:
//   MAX_HOLD   grant cycles before a forced release (2..255, timeout build only)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   req[7:0]   level requests, bit k = requester k
//   done       owner finished (only looked at while a grant is active)
//   gnt_valid  a grant is active
//   gnt_idx    index of the granted requester, 0 when idle
//   gnt[7:0]   one-hot grant, 8'h00 when idle
//   timeout    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0] state;
    logic [2:0] ptr;
    logic [2:0] pick_idx;
    logic       release_now;

`ifdef ARB_TIMEOUT_EN
    // The counter reaches HOLD_LAST during the MAX_HOLD-th grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
`else
    logic [7:0] unused_hold_cfg;
    assign unused_hold_cfg = 8'(MAX_HOLD);
    assign timeout         = 1'b0;
`endif

    // Search starts at the pointer and walks upward mod 8.  The result is
    // only used when some request bit is set.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] sel;
        logic [2:0] cand;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = p + 3'(i);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Winner selection and the release condition for the current owner.
    always_comb begin
        pick_idx    = rr_pick(req, ptr);
        release_now = done || !req[gnt_idx];
    end

    // Arbitration state machine; every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 3'd0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 3'd0;
            gnt       <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            timeout   <= 1'b0;
            hold_cnt  <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                    if (|req) begin
                        state     <= ST_BUSY;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= pick_idx;
                        gnt       <= 8'd1 << pick_idx;
                        ptr       <= pick_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= 8'd0;
`endif
                    end else begin
                        state     <= ST_IDLE;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= 3'd0;
                        gnt       <= 8'h00;
                    end
                end
                ST_BUSY: begin
                    // A normal release wins over a forced release in the same cycle.
                    if (release_now) begin
                        state     <= ST_IDLE;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= 3'd0;
                        gnt       <= 8'h00;
`ifdef ARB_TIMEOUT_EN
                        timeout   <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_IDLE;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= 3'd0;
                        gnt       <= 8'h00;
                        timeout   <= 1'b1;
                    end else begin
                        state     <= ST_BUSY;
                        hold_cnt  <= hold_cnt + 8'd1;
                        timeout   <= 1'b0;
                    end
`else
                    end else begin
                        state     <= ST_BUSY;
                    end
`endif
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_valid <= 1'b0;
                    gnt_idx   <= 3'd0;
                    gnt       <= 8'h00;
`ifdef ARB_TIMEOUT_EN
                    timeout   <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8 -- directed self-checking bench for rr_arbiter8.
// Inputs are driven 1 time unit after a rising edge.  Outputs are sampled at
// that same point, so each step() shows the result of the edge just taken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;

    logic [12:0] obs;
    logic [12:0] e;
    int          pass_cnt;
    int          total_cnt;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .timeout   (timeout)
    );

    assign obs = {gnt_valid, gnt_idx, gnt, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt_valid, gnt_idx, gnt, timeout}, built from the grant description.
    function automatic logic [12:0] exp_out(input logic v, input logic [2:0] i, input logic t);
        logic [7:0] g;
        g = v ? (8'd1 << i) : 8'h00;
        return {v, (v ? i : 3'd0), g, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            e = exp_out(1'b0, 3'd0, 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL reset_hold: got %h want %h", obs, e); else pass_cnt++;
        end
        rst = 1'b0;
        req = 8'h01;
        step();
        e = exp_out(1'b1, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL first_grant: got %h want %h", obs, e); else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
        e = exp_out(1'b0, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL first_release: got %h want %h", obs, e); else pass_cnt++;
    endtask

    task automatic test_alternate();
        logic [2:0] seq [4];
        seq = '{3'd0, 3'd7, 3'd0, 3'd7};
        do_reset();
        req = 8'h81;
        for (int n = 0; n < 4; n++) begin
            step();
            e = exp_out(1'b1, seq[n], 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL alt_grant%0d: got %h want %h", n, obs, e); else pass_cnt++;
            done = 1'b1;
            step();
            done = 1'b0;
            e = exp_out(1'b0, 3'd0, 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL alt_gap%0d: got %h want %h", n, obs, e); else pass_cnt++;
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h40;
        step();
        e = exp_out(1'b1, 3'd6, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL wrap_g6: got %h want %h", obs, e); else pass_cnt++;
        req = 8'h00;
        step();
        req = 8'h41;
        step();
        e = exp_out(1'b1, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL wrap_g0: got %h want %h", obs, e); else pass_cnt++;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        e = exp_out(1'b1, 3'd6, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL wrap_next6: got %h want %h", obs, e); else pass_cnt++;
        req = 8'h00;
        step();
    endtask

    task automatic test_release();
        do_reset();
        req = 8'h08;
        step();
        e = exp_out(1'b1, 3'd3, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_g3: got %h want %h", obs, e); else pass_cnt++;
        // Other requesters arriving mid-grant do not disturb the owner.
        req = 8'hF8;
        step();
        e = exp_out(1'b1, 3'd3, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_ignore: got %h want %h", obs, e); else pass_cnt++;
        req = 8'h00;
        step();
        e = exp_out(1'b0, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_drop: got %h want %h", obs, e); else pass_cnt++;
        req = 8'h08;
        step();
        e = exp_out(1'b1, 3'd3, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_regrant: got %h want %h", obs, e); else pass_cnt++;
        req  = 8'h00;
        done = 1'b1;
        step();
        e = exp_out(1'b0, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_both: got %h want %h", obs, e); else pass_cnt++;
        // done held while idle with no requests changes nothing.
        step();
        done = 1'b0;
        e = exp_out(1'b0, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL rel_idle_done: got %h want %h", obs, e); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h0C;
        for (int c = 0; c < 4; c++) begin
            step();
            e = exp_out(1'b1, 3'd2, 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL to_hold%0d: got %h want %h", c, obs, e); else pass_cnt++;
        end
`ifdef ARB_TIMEOUT_EN
        step();
        e = exp_out(1'b0, 3'd0, 1'b1);
        total_cnt++;
        if (obs !== e) $display("FAIL to_pulse: got %h want %h", obs, e); else pass_cnt++;
        step();
        e = exp_out(1'b1, 3'd3, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL to_next3: got %h want %h", obs, e); else pass_cnt++;
`else
        for (int c = 0; c < 6; c++) begin
            step();
            e = exp_out(1'b1, 3'd2, 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL to_unbounded%0d: got %h want %h", c, obs, e); else pass_cnt++;
        end
`endif
        req = 8'h00;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        step();
        e = exp_out(1'b1, 3'd4, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL ar_g4: got %h want %h", obs, e); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        e = exp_out(1'b0, 3'd0, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL ar_immediate: got %h want %h", obs, e); else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== e) $display("FAIL ar_held: got %h want %h", obs, e); else pass_cnt++;
        rst = 1'b0;
        req = 8'h20;
        step();
        e = exp_out(1'b1, 3'd5, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL ar_g5: got %h want %h", obs, e); else pass_cnt++;
        req = 8'h00;
        step();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        test_alternate();
        test_wrap();
        test_release();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Drives a 3-bit grant index into the team's 3-to-8 one-hot decoder path. The same one-hot grant is also produced locally, registered.
- Holds each grant until the owner signals done or drops its request. Pointer-based rotation makes the arbitration fair.

Parameters:
MAX_HOLD, 16, max cycles a grant may be held before forced release (only used with ARB_TIMEOUT_EN); legal range 2..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  8  request vector, bit k = requester k; level, held until served
done  input  1  current owner finished; sampled only while gnt_valid=1
gnt_valid  output  1  a grant is active
gnt_idx  output  3  index of granted requester; 0 when gnt_valid=0
gnt  output  8  one-hot grant (1<<gnt_idx when valid, else 8'h00)
timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset: clock and reset are fixed as above: one clock, clk; reset rst is asynchronous, active-high.
- On rst=1, immediately and independently of clk, force the following, and hold them while rst=1:
  - state=IDLE, ptr=0, gnt_valid=0, gnt_idx=0, gnt=8'h00, timeout=0, hold counter=0.
- All outputs are registered; no combinational path from req/done to outputs.
- State IDLE:
  - If req==0, stay in IDLE; outputs remain 0.
  - Otherwise select k = first set bit of req searching ptr, ptr+1, ... mod 8, with wrap-around 7->0.
  - At the next edge: state=BUSY, gnt_valid=1, gnt_idx=k, gnt=1<<k, ptr=(k+1) mod 8.
  - Latency: req asserted in cycle n -> grant visible in cycle n+1.
- State BUSY, release condition: done=1, OR req[gnt_idx]=0. Simultaneous done and req drop count as a single release.
- On release, at the next edge: state=IDLE, gnt_valid=0, gnt_idx=0, gnt=8'h00.
- The next grant appears one cycle later, so there is always at least one cycle with gnt_valid=0 between grants.
- Changes on other req bits during BUSY are ignored until IDLE.
- done is ignored in IDLE.
- ptr advances only on a grant, never on release or timeout.
- A sole requester is re-granted after each release: its slot is reached after a full wrap.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- With macro defined:
  - An 8-bit hold counter clears on grant and increments each BUSY cycle.
  - If no release occurs by the MAX_HOLD-th cycle of gnt_valid=1, force a release at that edge:
    - gnt_valid=0, gnt=0, gnt_idx=0, timeout=1 for exactly one cycle.
  - A normal release in the same cycle takes precedence: timeout stays 0.
  - ptr already points past the timed-out owner, so another pending requester wins next.
- Without macro: no counter is instantiated, timeout is constant 0, and grants are unbounded.

Test Plan:
1. rst=1 with req=8'hFF -> all outputs 0 throughout. Release rst, req=8'h01 -> one cycle later gnt_valid=1, gnt_idx=0, gnt=8'h01.
2. req=8'h81 held, done pulsed 1 cycle after each grant -> grant sequence idx 0,7,0,7, with one gnt_valid=0 cycle between grants.
3. Wrap-around: grant idx 6 and release (ptr=7), then req=8'h41 -> next grant idx 0, the following grant idx 6.
4. Grant idx 3 from req=8'h08, then drop req[3] with no done -> next edge gnt_valid=0, gnt=8'h00. Simultaneous done+drop -> identical single release.
5. ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h0C, no done -> idx 2 valid exactly 4 cycles, then timeout=1 for 1 cycle, then grant idx 3. Without macro: idx 2 held indefinitely, timeout=0.
6. Assert rst asynchronously mid-grant (between edges) -> outputs 0 immediately. After release, req=8'h20 -> grant idx 5 (ptr restarted at 0).
